// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit
// Description : Instruction-fetch stage sitting directly in front of the
//               instruction ROM. Holds the PC and selects the next PC
//               (sequential, jump or branch). Drives the ROM word address
//               and forwards the fetched word to decode. Any next-PC outside
//               the ROM window stops fetch with a sticky fault until reset.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RESET_PC   byte address loaded on reset (word-aligned, inside window)
//   ROM_AW     ROM word-address width; window = 0 .. (2^ROM_AW)*4-1 bytes
// Ports
//   clk         in   1       clock, rising edge
//   rst         in   1       synchronous reset, active-high
//   stall       in   1       hold PC this cycle
//   jump_taken  in   1       J-type redirect request
//   jump_index  in   26      J-type instr_index field
//   br_taken    in   1       branch redirect request (already resolved)
//   br_offset   in   16      signed word offset of the branch
//   rom_addr    out  ROM_AW  ROM word address, from the pc register only
//   rom_inst    in   32      ROM data, same cycle
//   pc          out  32      current PC (byte address)
//   pc_plus4    out  32      pc + 4 (link value)
//   inst        out  32      rom_inst while valid, otherwise NOP (0)
//   inst_valid  out  1       high only in RUN
//   fault       out  1       sticky out-of-window fault
//   fetch_cnt   out  32      number of accepted fetches (wraps)
// ============================================================================
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ROM_AW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              jump_taken,
  input  logic [25:0]       jump_index,
  input  logic              br_taken,
  input  logic [15:0]       br_offset,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_inst,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic              fault,
  output logic [31:0]       fetch_cnt
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_r, state_next;
  logic [31:0] pc_r, pc_next;
  logic        fault_r, fault_next;
  logic [31:0] fetch_cnt_r, fetch_cnt_next;

  logic [31:0] seq_target;
  logic [31:0] jump_target;
  logic [31:0] br_target;
  logic [31:0] target;
  logic        out_of_window;

  // ---------------------------------------------------------------------------
  // Target computation. Every candidate is word-aligned by construction, so
  // only the upper bits need checking against the ROM window.
  // ---------------------------------------------------------------------------
  assign seq_target  = pc_r + 32'd4;
  assign jump_target = {seq_target[31:28], jump_index, 2'b00};
  assign br_target   = seq_target + {{14{br_offset[15]}}, br_offset, 2'b00};

  always_comb begin
    target = seq_target;
    if (jump_taken) begin
      target = jump_target;
    end else if (br_taken) begin
      target = br_target;
    end
  end

  assign out_of_window = |target[31:ROM_AW+2];

  // ---------------------------------------------------------------------------
  // Next-state / next-PC logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_r;
    pc_next        = pc_r;
    fault_next     = fault_r;
    fetch_cnt_next = fetch_cnt_r;
    case (state_r)
      BOOT: begin
        state_next = RUN;
      end
      RUN: begin
        // A stalled requester keeps its request up, so nothing is lost here.
        if (!stall) begin
          if (out_of_window) begin
            fault_next = 1'b1;
            state_next = HALT;
          end else begin
            pc_next        = target;
            fetch_cnt_next = fetch_cnt_r + 32'd1;
          end
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= BOOT;
      pc_r        <= RESET_PC;
      fault_r     <= 1'b0;
      fetch_cnt_r <= 32'd0;
    end else begin
      state_r     <= state_next;
      pc_r        <= pc_next;
      fault_r     <= fault_next;
      fetch_cnt_r <= fetch_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. rom_addr is taken straight from the pc register so no request
  // input has a combinational path to the ROM address.
  // ---------------------------------------------------------------------------
  assign rom_addr   = pc_r[ROM_AW+1:2];
  assign pc         = pc_r;
  assign pc_plus4   = seq_target;
  assign inst_valid = (state_r == RUN);
  assign inst       = inst_valid ? rom_inst : 32'h0000_0000;
  assign fault      = fault_r;
  assign fetch_cnt  = fetch_cnt_r;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_unit
// Description : Self-checking bench for fetch_pc_unit: a table of directed
//               vectors plus hand-written multi-cycle sequences (loop, fault,
//               HALT hold, recovery, counter wrap).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

  localparam int ROM_AW = 5;

  logic              clk;
  logic              rst;
  logic              stall;
  logic              jump_taken;
  logic [25:0]       jump_index;
  logic              br_taken;
  logic [15:0]       br_offset;
  logic [ROM_AW-1:0] rom_addr;
  logic [31:0]       rom_inst;
  logic [31:0]       pc;
  logic [31:0]       pc_plus4;
  logic [31:0]       inst;
  logic              inst_valid;
  logic              fault;
  logic [31:0]       fetch_cnt;

  int total;
  int bad;

  fetch_pc_unit #(
    .RESET_PC(32'h0000_0000),
    .ROM_AW  (ROM_AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .jump_taken(jump_taken),
    .jump_index(jump_index),
    .br_taken  (br_taken),
    .br_offset (br_offset),
    .rom_addr  (rom_addr),
    .rom_inst  (rom_inst),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .inst      (inst),
    .inst_valid(inst_valid),
    .fault     (fault),
    .fetch_cnt (fetch_cnt)
  );

  // ROM model: each word carries its own address so inst is traceable.
  assign rom_inst = 32'hDEAD_0000 + {27'd0, rom_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        jt;
    logic [25:0] ji;
    logic        bt;
    logic [15:0] bo;
    logic [31:0] epc;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Compare every observable output against the expected architectural state.
  task automatic chk_all(input string tag, input logic [31:0] epc, input logic ev,
                         input logic ef, input logic [31:0] ecnt);
    logic [31:0] eaddr;
    eaddr = {27'd0, epc[6:2]};
    chk({tag, ".pc"},        pc, epc);
    chk({tag, ".pc_plus4"},  pc_plus4, epc + 32'd4);
    chk({tag, ".rom_addr"},  {27'd0, rom_addr}, eaddr);
    chk({tag, ".valid"},     {31'd0, inst_valid}, {31'd0, ev});
    chk({tag, ".fault"},     {31'd0, fault}, {31'd0, ef});
    chk({tag, ".inst"},      inst, ev ? (32'hDEAD_0000 + eaddr) : 32'h0);
    chk({tag, ".fetch_cnt"}, fetch_cnt, ecnt);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic jt, input logic [25:0] ji,
                       input logic bt, input logic [15:0] bo);
    stall      = s;
    jump_taken = jt;
    jump_index = ji;
    br_taken   = bt;
    br_offset  = bo;
  endtask

  task automatic set_vec(input int i, input logic s, input logic jt, input logic [25:0] ji,
                         input logic bt, input logic [15:0] bo,
                         input logic [31:0] epc, input logic [31:0] ecnt);
    vecs[i].stall = s;
    vecs[i].jt    = jt;
    vecs[i].ji    = ji;
    vecs[i].bt    = bt;
    vecs[i].bo    = bo;
    vecs[i].epc   = epc;
    vecs[i].ecnt  = ecnt;
  endtask

  // Reset then the BOOT cycle; leaves the DUT in RUN at pc=0, cnt=0.
  task automatic do_reset(input string tag);
    drive(1'b0, 1'b0, 26'd0, 1'b0, 16'd0);
    rst = 1'b1;
    step();
    step();
    chk_all({tag, ".boot"}, 32'h0, 1'b0, 1'b0, 32'd0);
    rst = 1'b0;
    step();
    chk_all({tag, ".run"}, 32'h0, 1'b1, 1'b0, 32'd0);
  endtask

  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(1'b0, 1'b0, 26'd0, 1'b0, 16'd0);

    //       idx stall jt  ji       bt   bo          pc          cnt
    set_vec(0,  0, 0, 26'h0, 0, 16'h0000, 32'h04, 32'd1);
    set_vec(1,  0, 0, 26'h0, 0, 16'h0000, 32'h08, 32'd2);
    set_vec(2,  0, 0, 26'h0, 0, 16'h0000, 32'h0C, 32'd3);
    set_vec(3,  0, 0, 26'h0, 0, 16'h0000, 32'h10, 32'd4);
    set_vec(4,  0, 1, 26'h5, 1, 16'hFFFE, 32'h14, 32'd5);  // jump beats branch
    set_vec(5,  0, 0, 26'h0, 0, 16'h0000, 32'h18, 32'd6);
    set_vec(6,  0, 0, 26'h0, 1, 16'hFFFE, 32'h14, 32'd7);  // 0x1C - 8
    set_vec(7,  0, 1, 26'h4, 0, 16'h0000, 32'h10, 32'd8);
    set_vec(8,  0, 0, 26'h0, 1, 16'hFFFE, 32'h0C, 32'd9);  // 0x14 - 8
    set_vec(9,  0, 0, 26'h0, 1, 16'h0003, 32'h1C, 32'd10); // 0x10 + 12
    set_vec(10, 0, 0, 26'h0, 0, 16'h0000, 32'h20, 32'd11);
    set_vec(11, 0, 0, 26'h0, 0, 16'h0000, 32'h24, 32'd12);
    set_vec(12, 0, 1, 26'h2, 0, 16'h0000, 32'h08, 32'd13);
    set_vec(13, 1, 1, 26'h1, 0, 16'h0000, 32'h08, 32'd13); // stalled
    set_vec(14, 1, 1, 26'h1, 0, 16'h0000, 32'h08, 32'd13);
    set_vec(15, 1, 1, 26'h1, 1, 16'h0001, 32'h08, 32'd13);
    set_vec(16, 0, 1, 26'h1, 0, 16'h0000, 32'h04, 32'd14); // released

    do_reset("reset");

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].stall, vecs[i].jt, vecs[i].ji, vecs[i].bt, vecs[i].bo);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].epc, 1'b1, 1'b0, vecs[i].ecnt);
    end

    // rom_addr must not follow request inputs combinationally.
    drive(1'b0, 1'b1, 26'h1F, 1'b1, 16'h0010);
    #1;
    chk("comb_path.rom_addr", {27'd0, rom_addr}, 32'd1);

    // Loop 0x08..0x24 three times.
    drive(1'b0, 1'b1, 26'h2, 1'b0, 16'h0);
    step();
    exp_pc  = 32'h08;
    exp_cnt = 32'd15;
    chk_all("loop.enter", exp_pc, 1'b1, 1'b0, exp_cnt);
    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < 8; k++) begin
        if (exp_pc == 32'h24) begin
          drive(1'b0, 1'b1, 26'h2, 1'b0, 16'h0);
          exp_pc = 32'h08;
        end else begin
          drive(1'b0, 1'b0, 26'h0, 1'b0, 16'h0);
          exp_pc = exp_pc + 32'd4;
        end
        exp_cnt = exp_cnt + 32'd1;
        step();
        chk_all($sformatf("loop%0d.%0d", it, k), exp_pc, 1'b1, 1'b0, exp_cnt);
      end
    end

    // Out-of-window jump (0x80) faults; PC and counter hold.
    drive(1'b0, 1'b1, 26'h20, 1'b0, 16'h0);
    step();
    chk_all("fault.jump", 32'h08, 1'b0, 1'b1, exp_cnt);
    for (int k = 0; k < 10; k++) begin
      drive(1'($urandom), 1'($urandom), 26'($urandom), 1'($urandom), 16'($urandom));
      step();
      chk_all($sformatf("halt%0d", k), 32'h08, 1'b0, 1'b1, exp_cnt);
    end

    // Recovery from HALT, then sequential step past the last word.
    do_reset("recover");
    drive(1'b0, 1'b1, 26'h1F, 1'b0, 16'h0);
    step();
    chk_all("last_word", 32'h7C, 1'b1, 1'b0, 32'd1);
    drive(1'b0, 1'b0, 26'h0, 1'b0, 16'h0);
    step();
    chk_all("fault.seq", 32'h7C, 1'b0, 1'b1, 32'd1);

    // Backward branch below address 0 wraps to 0xFFFFFFFC and faults.
    do_reset("rst2");
    drive(1'b0, 1'b0, 26'h0, 1'b1, 16'hFFFE);
    step();
    chk_all("fault.br_neg", 32'h00, 1'b0, 1'b1, 32'd0);

    // Counter wrap.
    do_reset("rst3");
    force dut.fetch_cnt_r = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt_r;
    #1;
    chk("wrap.pre", fetch_cnt, 32'hFFFF_FFFF);
    drive(1'b0, 1'b0, 26'h0, 1'b0, 16'h0);
    step();
    chk_all("wrap", 32'h04, 1'b1, 1'b0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
